// File: rtl/state_seq_pkg.sv
// Shared definitions for the state sequencer: FSM encoding and default widths.
package state_seq_pkg;

    localparam int DEF_STATE_W = 4;
    localparam int DEF_BLK_W   = 7;
    localparam int DEF_SEL_W   = 3;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/state_sequencer.sv
// Steps an externally computed next-state function from a loaded initial state
// until a halt state, a step limit, or an abort; config persists across runs.
module state_sequencer
    import state_seq_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int BLK_W   = DEF_BLK_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BLK_W-1:0]   cfg_blocks,
    input  logic [SEL_W-1:0]   cfg_selector,
    input  logic [STATE_W-1:0] cfg_init,
    input  logic [STATE_W-1:0] cfg_halt,
    input  logic [CNT_W-1:0]   cfg_steps,
    input  logic               start,
    input  logic               stop,
    output logic [BLK_W-1:0]   ns_blocks,
    output logic [SEL_W-1:0]   ns_selector,
    output logic [STATE_W-1:0] ns_current,
    input  logic [STATE_W-1:0] ns_next,
    output logic               state_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_count,
    output logic               halted
);

    seq_state_t         r_fsm;
    seq_state_t         w_fsm_next;

    logic               r_loaded;
    logic [BLK_W-1:0]   r_blocks;
    logic [SEL_W-1:0]   r_selector;
    logic [STATE_W-1:0] r_halt;
    logic [CNT_W-1:0]   r_steps;
    logic [STATE_W-1:0] r_cur;
    logic [CNT_W-1:0]   r_step_count;
    logic               r_halted;
    logic               r_state_valid;

    logic               w_xfer;
    logic               w_commit;
    logic               w_run_clear;
    logic               w_set_halt;
    logic [CNT_W-1:0]   w_step_inc;

    assign w_xfer     = cfg_valid && (r_fsm == ST_IDLE);
    assign w_step_inc = r_step_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next  = r_fsm;
        w_commit    = 1'b0;
        w_run_clear = 1'b0;
        w_set_halt  = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                // A start coinciding with a config transfer is dropped so the
                // run never mixes old and new configuration.
                if (start && r_loaded && !w_xfer) begin
                    w_run_clear = 1'b1;
                    w_fsm_next  = (r_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_fsm_next = ST_DONE;
                end else begin
                    w_commit = 1'b1;
                    if (ns_next == r_halt) begin
                        w_set_halt = 1'b1;
                        w_fsm_next = ST_DONE;
                    end
                    if (w_step_inc == r_steps) begin
                        w_fsm_next = ST_DONE;
                    end
                end
            end
            ST_DONE: w_fsm_next = ST_IDLE;
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loaded      <= 1'b0;
            r_blocks      <= '0;
            r_selector    <= '0;
            r_halt        <= '0;
            r_steps       <= '0;
            r_cur         <= '0;
            r_step_count  <= '0;
            r_halted      <= 1'b0;
            r_state_valid <= 1'b0;
        end else begin
            r_state_valid <= w_commit;
            if (w_xfer) begin
                r_loaded   <= 1'b1;
                r_blocks   <= cfg_blocks;
                r_selector <= cfg_selector;
                r_halt     <= cfg_halt;
                r_steps    <= cfg_steps;
                r_cur      <= cfg_init;
            end
            if (w_run_clear) begin
                r_step_count <= '0;
                r_halted     <= 1'b0;
            end
            if (w_commit) begin
                r_cur        <= ns_next;
                r_step_count <= w_step_inc;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign cfg_ready   = (r_fsm == ST_IDLE);
    assign busy        = (r_fsm == ST_RUN);
    assign done        = (r_fsm == ST_DONE);
    assign state_valid = r_state_valid;
    assign step_count  = r_step_count;
    assign halted      = r_halted;
    assign ns_blocks   = r_blocks;
    assign ns_selector = r_selector;
    assign ns_current  = r_cur;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed cycle-by-cycle vectors for state_sequencer with an increment-by-one
// next-state function, plus a pulse-counting run with a bounded wait.
module tb_state_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [6:0] cfg_blocks;
    logic [2:0] cfg_selector;
    logic [3:0] cfg_init;
    logic [3:0] cfg_halt;
    logic [7:0] cfg_steps;
    logic       start;
    logic       stop;
    logic [6:0] ns_blocks;
    logic [2:0] ns_selector;
    logic [3:0] ns_current;
    logic [3:0] ns_next;
    logic       state_valid;
    logic       busy;
    logic       done;
    logic [7:0] step_count;
    logic       halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ns_next = ns_current + 4'd1;

    state_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_blocks(cfg_blocks), .cfg_selector(cfg_selector),
        .cfg_init(cfg_init), .cfg_halt(cfg_halt), .cfg_steps(cfg_steps),
        .start(start), .stop(stop),
        .ns_blocks(ns_blocks), .ns_selector(ns_selector),
        .ns_current(ns_current), .ns_next(ns_next),
        .state_valid(state_valid), .busy(busy), .done(done),
        .step_count(step_count), .halted(halted)
    );

    typedef struct {
        logic       rst, cv;
        logic [3:0] init, halt;
        logic [7:0] steps;
        logic       start, stop;
        logic       rdy, busy, done, sv;
        logic [7:0] cnt;
        logic       h;
        logic [3:0] cur;
        logic       cfg;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, input logic cv, input logic [3:0] ini,
                              input logic [3:0] hlt, input logic [7:0] stp,
                              input logic st, input logic sp,
                              input logic e_rdy, input logic e_busy, input logic e_done,
                              input logic e_sv, input logic [7:0] e_cnt, input logic e_h,
                              input logic [3:0] e_cur, input logic e_cfg);
        vec_t t;
        t.rst = r; t.cv = cv; t.init = ini; t.halt = hlt; t.steps = stp;
        t.start = st; t.stop = sp;
        t.rdy = e_rdy; t.busy = e_busy; t.done = e_done; t.sv = e_sv;
        t.cnt = e_cnt; t.h = e_h; t.cur = e_cur; t.cfg = e_cfg;
        tbl.push_back(t);
    endfunction

    task automatic drive_idle();
        rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        int pulses;
        int budget;
        logic got_done;

        cfg_blocks = 7'h55; cfg_selector = 3'h5;
        cfg_init = '0; cfg_halt = '0; cfg_steps = '0;
        drive_idle();

        //  rst cv ini  hlt  stp  st sp | rdy bsy dn sv cnt h cur cfg
        v(1, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0); // reset
        v(0, 0, 0, 0,  0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0); // start unloaded
        v(0, 1, 0, 15, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1); // load steps=0
        v(0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1); // zero-step run
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        v(0, 1, 0, 15, 5, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1); // load steps=5
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 1, 0, 1, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 2, 0, 2, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 3, 0, 3, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 4, 0, 4, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1, 5, 0, 5, 1); // step limit
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 5, 0, 5, 1);
        v(0, 1, 0, 3,  5, 0, 0,   1, 0, 0, 0, 5, 0, 0, 1); // load halt=3
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 1, 0, 1, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 2, 0, 2, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1, 3, 1, 3, 1); // halt hit
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 3, 1, 3, 1);
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 3, 1); // rerun from 3
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 1, 0, 4, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 2, 0, 5, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 3, 0, 6, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 4, 0, 7, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1, 5, 0, 8, 1);
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 5, 0, 8, 1);
        v(0, 1, 0, 15, 5, 0, 0,   1, 0, 0, 0, 5, 0, 0, 1); // stop test
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 1, 0, 1, 1);
        v(0, 0, 0, 0,  0, 0, 1,   0, 0, 1, 0, 1, 0, 1, 1); // stop, no commit
        v(0, 0, 0, 0,  0, 0, 1,   1, 0, 0, 0, 1, 0, 1, 1); // stop ignored
        v(0, 1, 2, 15, 2, 1, 0,   1, 0, 0, 0, 1, 0, 2, 1); // cfg+start
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 2, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 1, 0, 3, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1, 2, 0, 4, 1);
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 2, 0, 4, 1);
        v(0, 1, 0, 15, 9, 0, 0,   1, 0, 0, 0, 2, 0, 0, 1); // reset test
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 1, 0, 1, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 1, 2, 0, 2, 1);
        v(1, 0, 0, 0,  0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0); // rst mid-run
        v(0, 0, 0, 0,  0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0); // unloaded again
        v(0, 1, 0, 1,  1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1); // halt=1 steps=1
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 0, 1,   0, 0, 1, 0, 0, 0, 0, 1); // stop beats both
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1, 1, 1, 1, 1); // halt+limit
        v(0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 1, 1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            logic [6:0] e_blk;
            logic [2:0] e_sel;
            rst = tbl[i].rst; cfg_valid = tbl[i].cv;
            cfg_init = tbl[i].init; cfg_halt = tbl[i].halt; cfg_steps = tbl[i].steps;
            start = tbl[i].start; stop = tbl[i].stop;
            @(posedge clk);
            #1;
            e_blk = tbl[i].cfg ? 7'h55 : 7'h00;
            e_sel = tbl[i].cfg ? 3'h5 : 3'h0;
            checks++;
            if ({cfg_ready, busy, done, state_valid, step_count, halted, ns_current, ns_blocks, ns_selector} !==
                {tbl[i].rdy, tbl[i].busy, tbl[i].done, tbl[i].sv, tbl[i].cnt, tbl[i].h, tbl[i].cur, e_blk, e_sel}) begin
                errors++;
                $display("FAIL row%0d: got rdy=%b busy=%b done=%b sv=%b cnt=%0d h=%b cur=%0d blk=%h sel=%h | want rdy=%b busy=%b done=%b sv=%b cnt=%0d h=%b cur=%0d blk=%h sel=%h",
                         i, cfg_ready, busy, done, state_valid, step_count, halted, ns_current, ns_blocks, ns_selector,
                         tbl[i].rdy, tbl[i].busy, tbl[i].done, tbl[i].sv, tbl[i].cnt, tbl[i].h, tbl[i].cur, e_blk, e_sel);
            end else begin
                $display("row%0d ok: cnt=%0d cur=%0d busy=%b done=%b sv=%b", i, step_count, ns_current, busy, done, state_valid);
            end
        end

        // Free-running five-step run from state 7, counted with a bounded wait.
        drive_idle();
        cfg_valid = 1'b1; cfg_init = 4'd7; cfg_halt = 4'd15; cfg_steps = 8'd5;
        @(posedge clk); #1;
        drive_idle();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; got_done = 1'b0; budget = 30;
        while (!got_done && budget > 0) begin
            @(posedge clk); #1;
            if (state_valid) pulses++;
            if (done) got_done = 1'b1;
            budget--;
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL run_timeout: done not seen within 30 cycles, got done=%b want 1", done);
        end
        checks++;
        if (pulses != 5 || ns_current != 4'd12 || step_count != 8'd5 || halted != 1'b0) begin
            errors++;
            $display("FAIL run_pulses: got pulses=%0d cur=%0d cnt=%0d h=%b want pulses=5 cur=12 cnt=5 h=0",
                     pulses, ns_current, step_count, halted);
        end else begin
            $display("run ok: pulses=%0d cur=%0d cnt=%0d", pulses, ns_current, step_count);
        end
        @(posedge clk); #1;
        checks++;
        if (cfg_ready !== 1'b1 || done !== 1'b0 || step_count !== 8'd5) begin
            errors++;
            $display("FAIL run_after: got rdy=%b done=%b cnt=%0d want rdy=1 done=0 cnt=5",
                     cfg_ready, done, step_count);
        end else begin
            $display("after ok: rdy=%b cnt=%0d", cfg_ready, step_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
